sdm2_dac_echip65: RTL and testbench
===================================

# sdm2_dac_echip65

Second-order, single-bit digital sigma-delta modulator with a zero-order-hold interpolator: accepts one signed multi-bit sample per INTERP_FACTOR clocks via a valid/ready handshake and emits a 1-bit density-modulated stream at the clk rate. It is the transmit end of the eChip65 bitstream path. It drives on-chip DAC stimulus, and its output can be looped directly into the CIC3 decimator's `in` port for self-test.

## Interface
- INTERP_FACTOR, 256: output bits per input sample; power of two.
- CNT_WIDTH, $clog2(INTERP_FACTOR): frame counter width.
- IN_WIDTH, 16: signed input sample width.
- ACC_WIDTH, IN_WIDTH+4: integrator width.
- clk  input  1  modulator clock; one output bit per cycle.
- reset_n  input  1  asynchronous, active-low reset.
- en  input  1  run enable; low freezes all state.
- in_data  input  IN_WIDTH  signed two's-complement sample.
- in_valid  input  1  in_data valid.
- in_ready  output  1  load slot; sample accepted when in_valid && in_ready.
- clear_underrun  input  1  synchronous clear of the underrun flag.
- bit_out  output  1  modulator bitstream; 1 = +FS, 0 = -FS.
- underrun  output  1  sticky flag; a load slot passed without in_valid.

## Operation
- FS = 2^(IN_WIDTH-1); LIM = 3*FS/4 (24576 for IN_WIDTH=16).
- Frame counter: increments when en=1 and wraps INTERP_FACTOR-1 -> 0.
- in_ready = en && (count == INTERP_FACTOR-1). This is combinational from the registered counter and is high for exactly one cycle per frame.
- Load slot with in_valid=1: x_hold <= clamp(in_data, -LIM, +LIM).
- Load slot with in_valid=0: x_hold is unchanged and underrun <= 1.
- If an underrun event and clear_underrun occur in the same cycle, set wins.
- Modulator, every en=1 cycle, using the old register values:
  - y = bit_out ? +FS : -FS
  - s1 = i1 + x_hold - y
  - s2 = i2 + i1 - y
  - i1 <= sat(s1); i2 <= sat(s2); bit_out <= (s2 >= 0)
- Sums are computed at ACC_WIDTH+1 bits. sat() clamps to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]. Saturation is unreachable with clamped input; it is a safety net only.
- en=0 freezes the counter, x_hold, i1, i2 and bit_out. in_ready=0 while en=0, and underrun is not set.
- Reset values: count=0, x_hold=0, i1=0, i2=0, bit_out=0, underrun=0, in_ready=0.

## Timing
- Everything updates on posedge clk; reset_n is asynchronous assert, synchronous-to-clk deassert at the system level.
- The first load slot is the INTERP_FACTOR-th enabled cycle after reset (count=255).
- Latency:
  - A sample accepted at edge k reaches i1 at edge k+1.
  - It first influences bit_out at edge k+2.
- Steady-state ones density = (x_hold + FS) / (2*FS).
- Reset mid-frame aborts the frame; the next load slot is again INTERP_FACTOR enabled cycles later.
- Changing in_data outside the load slot has no effect.

## Structure
- Package echip65_sdm_pkg holds:
  - FS and LIM localparam functions of IN_WIDTH.
  - The sat() and clamp() functions.
- Sub-module sdm2_core holds the loop: i1, i2, bit_out, enable and x input.
- Top sdm2_dac_echip65 holds the frame counter, handshake, x_hold and underrun.

## Test plan
- Reset, then en=1 with x_hold=0, first cycle: y=-32768 gives i1=32768, i2=32768, bit_out=1 at edge 1. All outputs read 0 during reset.
- in_data=0 held for every slot: after 1024 settling cycles, every aligned 256-bit window contains 128±2 ones. The looped-back CIC3 output is within 1% of 2^23.
- in_data=+24576: each window has 224±2 ones, and the CIC3 output is within 1% of 14680064. in_data=-24576 gives 32±2 ones.
- Clamp: in_data=+32767 gives x_hold=24576; in_data=-32768 gives x_hold=-24576. Neither i1 nor i2 ever saturates.
- Underrun:
  - in_valid=0 at a slot: underrun rises the next edge and x_hold is unchanged.
  - clear_underrun clears it.
  - Clear coincident with a new underrun leaves the flag 1.
- Freeze and reset:
  - en=0 for 100 cycles mid-frame: state and bit_out are frozen, and the next in_ready is delayed by exactly 100 cycles.
  - reset_n pulse mid-frame: all registers return to 0 immediately.

Source files
------------

// File: rtl/sdm2_dac_echip65_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | echip65_sdm_pkg                                                      |
// | Full-scale helpers and saturation/clamp arithmetic for the eChip65   |
// | second-order sigma-delta DAC.                                        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package echip65_sdm_pkg;

  localparam int c_DEF_IN_WIDTH = 16;
  localparam int c_DEF_INTERP   = 256;

  // Full scale of a signed IN_WIDTH-bit sample.
  function automatic longint fs_val(input int in_width);
    return longint'(1) <<< (in_width - 1);
  endfunction

  // Input limit keeping the second-order loop well inside its stable region.
  function automatic longint lim_val(input int in_width);
    return (longint'(3) * fs_val(in_width)) / longint'(4);
  endfunction

  function automatic longint sat(input longint v, input int width);
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (width - 1)) - longint'(1);
    lo = -(longint'(1) <<< (width - 1));
    if (v > hi) begin
      return hi;
    end
    if (v < lo) begin
      return lo;
    end
    return v;
  endfunction

  function automatic longint clamp(input longint v, input longint lim);
    if (v > lim) begin
      return lim;
    end
    if (v < -lim) begin
      return -lim;
    end
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sdm2_dac_echip65_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sdm2_dac_echip65_if                                                  |
// | Sample valid/ready handshake into the sigma-delta DAC.               |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface sdm2_dac_echip65_if #(
  parameter int IN_WIDTH = 16
);

  logic signed [IN_WIDTH-1:0] in_data;
  logic                       in_valid;
  logic                       in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );

endinterface
`default_nettype wire

// File: rtl/sdm2_dac_echip65_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sdm2_core                                                            |
// | Second-order single-bit noise-shaping loop with saturating           |
// | integrators; one output bit per enabled clock.                       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sdm2_core
  import echip65_sdm_pkg::*;
#(
  parameter int IN_WIDTH  = 16,
  parameter int ACC_WIDTH = IN_WIDTH + 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       en,
  input  logic signed [IN_WIDTH-1:0] x,
  output logic                       bit_out
);

  localparam int c_SUM_W = ACC_WIDTH + 1;
  localparam logic signed [c_SUM_W-1:0] c_FS = c_SUM_W'(fs_val(IN_WIDTH));

  logic signed [ACC_WIDTH-1:0] r_i1;
  logic signed [ACC_WIDTH-1:0] r_i2;
  logic                        r_bit;

  logic signed [c_SUM_W-1:0]   w_i1_ext;
  logic signed [c_SUM_W-1:0]   w_i2_ext;
  logic signed [c_SUM_W-1:0]   w_x_ext;
  logic signed [c_SUM_W-1:0]   w_y;
  logic signed [c_SUM_W-1:0]   w_s1;
  logic signed [c_SUM_W-1:0]   w_s2;
  logic signed [ACC_WIDTH-1:0] w_i1_nxt;
  logic signed [ACC_WIDTH-1:0] w_i2_nxt;

  // Both sums use the previous-cycle i1 and feedback bit (classic delayed loop).
  always_comb begin
    w_i1_ext = {{(c_SUM_W-ACC_WIDTH){r_i1[ACC_WIDTH-1]}}, r_i1};
    w_i2_ext = {{(c_SUM_W-ACC_WIDTH){r_i2[ACC_WIDTH-1]}}, r_i2};
    w_x_ext  = {{(c_SUM_W-IN_WIDTH){x[IN_WIDTH-1]}}, x};
    w_y      = r_bit ? c_FS : -c_FS;
    w_s1     = w_i1_ext + w_x_ext - w_y;
    w_s2     = w_i2_ext + w_i1_ext - w_y;
    w_i1_nxt = ACC_WIDTH'(sat(longint'(w_s1), ACC_WIDTH));
    w_i2_nxt = ACC_WIDTH'(sat(longint'(w_s2), ACC_WIDTH));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_i1  <= '0;
      r_i2  <= '0;
      r_bit <= 1'b0;
    end else if (en) begin
      r_i1  <= w_i1_nxt;
      r_i2  <= w_i2_nxt;
      r_bit <= ~w_s2[c_SUM_W-1];
    end
  end

  assign bit_out = r_bit;

endmodule
`default_nettype wire

// File: rtl/sdm2_dac_echip65.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sdm2_dac_echip65                                                     |
// | Zero-order-hold interpolator and sample handshake feeding the        |
// | second-order sigma-delta bitstream DAC.                              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sdm2_dac_echip65
  import echip65_sdm_pkg::*;
#(
  parameter int INTERP_FACTOR = 256,
  parameter int CNT_WIDTH     = $clog2(INTERP_FACTOR),
  parameter int IN_WIDTH      = 16,
  parameter int ACC_WIDTH     = IN_WIDTH + 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   en,
  sdm2_dac_echip65_if.slave      smp,
  input  logic                   clear_underrun,
  output logic                   bit_out,
  output logic                   underrun
);

  localparam logic [CNT_WIDTH-1:0] c_LAST = CNT_WIDTH'(INTERP_FACTOR - 1);
  localparam longint               c_LIM  = lim_val(IN_WIDTH);

  logic [CNT_WIDTH-1:0]       r_count;
  logic signed [IN_WIDTH-1:0] r_x_hold;
  logic                       r_underrun;

  logic                       w_slot;
  logic                       w_load;
  logic                       w_miss;
  logic signed [IN_WIDTH-1:0] w_x_clamped;

  always_comb begin
    w_slot      = en && (r_count == c_LAST);
    w_load      = w_slot && smp.in_valid;
    w_miss      = w_slot && !smp.in_valid;
    w_x_clamped = IN_WIDTH'(clamp(longint'(smp.in_data), c_LIM));
  end

  assign smp.in_ready = w_slot;

  // Power-of-two frame length lets the counter wrap on its own.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count  <= '0;
      r_x_hold <= '0;
    end else if (en) begin
      r_count <= r_count + CNT_WIDTH'(1);
      if (w_load) begin
        r_x_hold <= w_x_clamped;
      end
    end
  end

  // A missed slot in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_underrun <= 1'b0;
    end else if (w_miss) begin
      r_underrun <= 1'b1;
    end else if (clear_underrun) begin
      r_underrun <= 1'b0;
    end
  end

  assign underrun = r_underrun;

  sdm2_core #(
    .IN_WIDTH  (IN_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_core (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .x       (r_x_hold),
    .bit_out (bit_out)
  );

endmodule
`default_nettype wire

// File: tb/tb_sdm2_dac_echip65.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sdm2_dac_echip65                                                  |
// | Self-checking bench: cycle model scoreboard plus density windows.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_sdm2_dac_echip65;

  localparam int N       = 256;
  localparam int W       = 16;
  localparam int FS      = 32768;
  localparam int LIM     = 24576;
  localparam int ACC_MAX = 524287;
  localparam int ACC_MIN = -524288;

  typedef struct {
    int bit_out;
    int underrun;
  } exp_t;

  typedef struct {
    int data;
    int exp_x;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n;
  logic en;
  logic clear_underrun;
  logic bit_out;
  logic underrun;

  sdm2_dac_echip65_if #(.IN_WIDTH(W)) smp ();

  sdm2_dac_echip65 #(
    .INTERP_FACTOR (N),
    .IN_WIDTH      (W)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .en             (en),
    .smp            (smp),
    .clear_underrun (clear_underrun),
    .bit_out        (bit_out),
    .underrun       (underrun)
  );

  always #5 clk = ~clk;

  int   n_chk  = 0;
  int   n_fail = 0;
  int   m_cnt, m_x, m_i1, m_i2, m_bit, m_und;
  int   cur_data;
  exp_t sb[$];

  task automatic check(input string name, input logic signed [31:0] act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    n_chk++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  function automatic int sat_m(input int v);
    return (v > ACC_MAX) ? ACC_MAX : (v < ACC_MIN) ? ACC_MIN : v;
  endfunction

  function automatic int clamp_m(input int v);
    return (v > LIM) ? LIM : (v < -LIM) ? -LIM : v;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_x = 0; m_i1 = 0; m_i2 = 0; m_bit = 0; m_und = 0;
  endtask

  // One clock: predict, push, clock, pop and compare.
  task automatic step(output int rdy);
    exp_t e;
    int   y, s1, s2;
    bit   slot;
    slot = en && (m_cnt == N - 1);
    check("in_ready", smp.in_ready, int'(slot));
    rdy = int'(slot);
    y  = (m_bit != 0) ? FS : -FS;
    s1 = m_i1 + m_x - y;
    s2 = m_i2 + m_i1 - y;
    if (en) begin
      m_i1  = sat_m(s1);
      m_i2  = sat_m(s2);
      m_bit = (s2 >= 0) ? 1 : 0;
      m_cnt = (m_cnt + 1) % N;
      if (slot && smp.in_valid) m_x = clamp_m(int'(smp.in_data));
    end
    if (slot && !smp.in_valid) m_und = 1;
    else if (clear_underrun) m_und = 0;
    e.bit_out  = m_bit;
    e.underrun = m_und;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("bit_out", bit_out, e.bit_out);
    check("underrun", underrun, e.underrun);
  endtask

  // Off-slot data is scrambled; it must never reach the modulator.
  task automatic drive_step(output int rdy);
    smp.in_data = (m_cnt == N - 1) ? W'(cur_data) : W'($urandom);
    step(rdy);
  endtask

  task automatic run_to_load();
    int rdy;
    int k;
    rdy = 0;
    k = 0;
    while (!rdy && k < 2 * N + 200) begin
      drive_step(rdy);
      k++;
    end
    if (!rdy) check("slot_timeout", k, -1);
  endtask

  task automatic advance_to(input int cnt);
    int rdy;
    int k;
    k = 0;
    while (m_cnt != cnt && k < 2 * N) begin
      drive_step(rdy);
      k++;
    end
  endtask

  vec_t vecs[6];
  int   rdy, steps, ones, frozen_bit;

  initial begin
    vecs[0] = '{0, 0};
    vecs[1] = '{24576, 24576};
    vecs[2] = '{-24576, -24576};
    vecs[3] = '{32767, 24576};
    vecs[4] = '{-32768, -24576};
    vecs[5] = '{8192, 8192};

    reset_n = 1'b0; en = 1'b0; clear_underrun = 1'b0;
    smp.in_valid = 1'b0; smp.in_data = '0; cur_data = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_bit_out", bit_out, 0);
    check("rst_underrun", underrun, 0);
    check("rst_in_ready", smp.in_ready, 0);

    reset_n = 1'b1;
    en = 1'b1;
    smp.in_valid = 1'b1;
    drive_step(rdy);
    check("first_bit", bit_out, 1);
    steps = 1;
    while (!rdy && steps < 2 * N) begin
      drive_step(rdy);
      steps++;
    end
    check("first_slot", steps, N);

    // Density windows aligned to frame boundaries.
    for (int v = 0; v < 6; v++) begin
      cur_data = vecs[v].data;
      repeat (5) run_to_load();
      ones = 0;
      for (int i = 0; i < N; i++) begin
        drive_step(rdy);
        ones += int'(bit_out);
      end
      check_rng($sformatf("ones_window_%0d", vecs[v].data), ones,
                (vecs[v].exp_x + FS) * N / (2 * FS) - 2,
                (vecs[v].exp_x + FS) * N / (2 * FS) + 2);
    end

    // Underrun: set, clear, then clear coincident with a new miss.
    cur_data = 4096;
    smp.in_valid = 1'b0;
    run_to_load();
    check("underrun_set", underrun, 1);
    smp.in_valid = 1'b1;
    clear_underrun = 1'b1;
    drive_step(rdy);
    clear_underrun = 1'b0;
    check("underrun_clear", underrun, 0);
    advance_to(N - 1);
    smp.in_valid = 1'b0;
    clear_underrun = 1'b1;
    drive_step(rdy);
    check("set_wins_slot", rdy, 1);
    check("set_wins", underrun, 1);
    smp.in_valid = 1'b1;
    drive_step(rdy);
    clear_underrun = 1'b0;

    // Freeze mid-frame for 100 cycles.
    run_to_load();
    steps = 0;
    repeat (100) begin
      drive_step(rdy);
      steps++;
    end
    en = 1'b0;
    frozen_bit = int'(bit_out);
    repeat (100) begin
      drive_step(rdy);
      steps++;
      check("frozen_bit", bit_out, frozen_bit);
    end
    en = 1'b1;
    rdy = 0;
    while (!rdy && steps < 3 * N) begin
      drive_step(rdy);
      steps++;
    end
    check("slot_period_frozen", steps, N + 100);

    // Asynchronous reset mid-frame with flag and bit set.
    smp.in_valid = 1'b0;
    run_to_load();
    smp.in_valid = 1'b1;
    steps = 0;
    while (bit_out !== 1'b1 && steps < 50) begin
      drive_step(rdy);
      steps++;
    end
    check("pre_reset_bit", bit_out, 1);
    reset_n = 1'b0;
    #2;
    check("mid_rst_bit_out", bit_out, 0);
    check("mid_rst_underrun", underrun, 0);
    check("mid_rst_in_ready", smp.in_ready, 0);
    model_reset();
    sb.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    steps = 0;
    rdy = 0;
    while (!rdy && steps < 2 * N) begin
      drive_step(rdy);
      steps++;
    end
    check("slot_after_reset", steps, N);

    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
